// File: rtl/fc_demux_pkg.sv
// ============================================================================
// Module      : fc_demux_pkg
// Description : Shared types, constants and the region-match helper for the
//               FC core bus demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_demux_pkg;

    // Rules are held at a fixed wide width so the table is independent of
    // the instance address width; narrower addresses are zero-extended.
    localparam int unsigned FC_DEMUX_RULE_AW = 64;

    // Read data returned by the internal error responder.
    localparam logic [31:0] FC_DEMUX_ERR_RDATA = 32'hBADA_CCE5;

    typedef struct packed {
        logic [FC_DEMUX_RULE_AW-1:0] start;     // inclusive
        logic [FC_DEMUX_RULE_AW-1:0] end_;      // exclusive
        logic                        alias_en;  // also match bounds XOR mask
    } addr_rule_t;

    typedef enum logic [0:0] {
        ERR_IDLE = 1'b0,
        ERR_RESP = 1'b1
    } err_state_e;

    // True when addr falls inside the rule region, or inside its aliased
    // copy (both bounds XOR mask) when aliasing is enabled for the rule.
    function automatic logic rule_match(
        input logic [FC_DEMUX_RULE_AW-1:0] addr,
        input addr_rule_t                  rule,
        input logic [FC_DEMUX_RULE_AW-1:0] mask
    );
        logic w_direct;
        logic w_aliased;
        w_direct  = (addr >= rule.start) && (addr < rule.end_);
        w_aliased = rule.alias_en &&
                    (addr >= (rule.start ^ mask)) &&
                    (addr <  (rule.end_  ^ mask));
        return w_direct || w_aliased;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_demux_addr_decode.sv
// ============================================================================
// Module      : fc_demux_addr_decode
// Description : Combinational rule-table address decoder. Selects the lowest
//               matching port index; flags addresses no rule contains
//               (o_sel is 0 in that case).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_demux_addr_decode #(
    parameter int unsigned           N_PORTS    = 2,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           SEL_W      = 2,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR [N_PORTS] = '{default: '0},
    parameter logic [ADDR_WIDTH-1:0] END_ADDR   [N_PORTS] = '{default: '0},
    parameter logic [N_PORTS-1:0]    ALIAS_EN   = '0,
    parameter logic [ADDR_WIDTH-1:0] ALIAS_MASK = ADDR_WIDTH'(32'h1C00_0000)
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [SEL_W-1:0]      o_sel,
    output logic                  o_unmapped
);
    import fc_demux_pkg::*;

    logic [FC_DEMUX_RULE_AW-1:0] w_addr;
    logic [FC_DEMUX_RULE_AW-1:0] w_mask;
    addr_rule_t                  w_rules [N_PORTS];
    logic [N_PORTS-1:0]          w_match;

    assign w_addr = FC_DEMUX_RULE_AW'(i_addr);
    assign w_mask = FC_DEMUX_RULE_AW'(ALIAS_MASK);

    for (genvar i = 0; i < int'(N_PORTS); i++) begin : g_rules
        assign w_rules[i] = '{start:    FC_DEMUX_RULE_AW'(START_ADDR[i]),
                              end_:     FC_DEMUX_RULE_AW'(END_ADDR[i]),
                              alias_en: ALIAS_EN[i]};
        assign w_match[i] = rule_match(w_addr, w_rules[i], w_mask);
    end

    // Priority encode: scan downwards so the lowest matching index wins.
    always_comb begin
        o_sel      = '0;
        o_unmapped = 1'b1;
        for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_sel      = SEL_W'(i);
                o_unmapped = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fc_bus_demux.sv
// ============================================================================
// Module      : fc_bus_demux
// Description : Address demultiplexer from one FC core memory port to
//               N_PORTS TCDM-style master ports. Tracks outstanding
//               transactions and only lets a new port be addressed once all
//               earlier responses have returned, keeping responses in order.
//               Optional feature macro: FC_DEMUX_ERR_SLAVE_EN - an internal
//               error responder answers unmapped requests (r_opc=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_bus_demux #(
    parameter int unsigned           N_PORTS         = 2,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           MAX_OUTSTANDING = 4,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR [N_PORTS] = '{default: '0},
    parameter logic [ADDR_WIDTH-1:0] END_ADDR   [N_PORTS] = '{default: '0},
    parameter logic [N_PORTS-1:0]    ALIAS_EN        = '0,
    parameter logic [ADDR_WIDTH-1:0] ALIAS_MASK      = ADDR_WIDTH'(32'h1C00_0000)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // core side
    input  logic                    s_req_i,
    input  logic [ADDR_WIDTH-1:0]   s_add_i,
    input  logic                    s_wen_i,
    input  logic [DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_be_i,
    output logic                    s_gnt_o,
    output logic                    s_r_valid_o,
    output logic [DATA_WIDTH-1:0]   s_r_rdata_o,
    output logic                    s_r_opc_o,
    // master ports
    output logic [N_PORTS-1:0]      m_req_o,
    output logic [ADDR_WIDTH-1:0]   m_add_o   [N_PORTS],
    output logic [N_PORTS-1:0]      m_wen_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o [N_PORTS],
    output logic [DATA_WIDTH/8-1:0] m_be_o    [N_PORTS],
    input  logic [N_PORTS-1:0]      m_gnt_i,
    input  logic [N_PORTS-1:0]      m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   m_r_rdata_i [N_PORTS],
    input  logic [N_PORTS-1:0]      m_r_opc_i
);
    import fc_demux_pkg::*;

    localparam int unsigned SEL_W = $clog2(N_PORTS + 1);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Port index N_PORTS is reserved for the internal error responder.
    localparam logic [SEL_W-1:0] c_err_port = SEL_W'(N_PORTS);
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(MAX_OUTSTANDING);

    logic [SEL_W-1:0]      w_sel_dec;
    logic                  w_unmapped;
    logic [SEL_W-1:0]      w_sel;
    logic                  w_allow;
    logic                  w_slave_gnt;
    logic                  w_err_valid;
    logic                  w_rsp_valid_raw;
    logic                  w_rsp_valid;
    logic [DATA_WIDTH-1:0] w_rsp_rdata;
    logic                  w_rsp_opc;

    logic [CNT_W-1:0]      r_cnt;
    logic [SEL_W-1:0]      r_last_port;

    fc_demux_addr_decode #(
        .N_PORTS    (N_PORTS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SEL_W      (SEL_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR),
        .ALIAS_EN   (ALIAS_EN),
        .ALIAS_MASK (ALIAS_MASK)
    ) u_decode (
        .i_addr     (s_add_i),
        .o_sel      (w_sel_dec),
        .o_unmapped (w_unmapped)
    );

`ifdef FC_DEMUX_ERR_SLAVE_EN
    // Unmapped requests target the error responder.
    assign w_sel = w_unmapped ? c_err_port : w_sel_dec;

    err_state_e r_err_state;
    err_state_e w_err_state_nxt;

    // Error responder state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_state <= ERR_IDLE;
        end else begin
            r_err_state <= w_err_state_nxt;
        end
    end

    // A granted unmapped request is answered exactly one cycle later.
    always_comb begin
        w_err_state_nxt = ERR_IDLE;
        w_err_valid     = 1'b0;
        if (s_gnt_o && (w_sel == c_err_port)) begin
            w_err_state_nxt = ERR_RESP;
        end
        if (r_err_state == ERR_RESP) begin
            w_err_valid = 1'b1;
        end
    end
`else
    // Without the error responder, unmapped requests fall through to port 0.
    assign w_sel       = w_unmapped ? '0 : w_sel_dec;
    assign w_err_valid = 1'b0;
`endif

    // Registered count only: a response never frees a slot in its own cycle.
    assign w_allow = (r_cnt < c_cnt_max) &&
                     ((r_cnt == '0) || (w_sel == r_last_port));

    for (genvar i = 0; i < int'(N_PORTS); i++) begin : g_req
        assign m_req_o[i]   = s_req_i && (w_sel == SEL_W'(i)) && w_allow;
        assign m_add_o[i]   = s_add_i;
        assign m_wen_o[i]   = s_wen_i;
        assign m_wdata_o[i] = s_wdata_i;
        assign m_be_o[i]    = s_be_i;
    end

    // Grant comes from the selected slave; the error responder is always ready.
    always_comb begin
        w_slave_gnt = 1'b0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (w_sel == SEL_W'(i)) begin
                w_slave_gnt = m_gnt_i[i];
            end
        end
        if (w_sel == c_err_port) begin
            w_slave_gnt = 1'b1;
        end
        s_gnt_o = s_req_i && w_slave_gnt && w_allow;
    end

    // Route the response from the port owning the outstanding transactions;
    // anything arriving with nothing outstanding is dropped.
    always_comb begin
        w_rsp_valid_raw = 1'b0;
        w_rsp_rdata     = '0;
        w_rsp_opc       = 1'b0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (r_last_port == SEL_W'(i)) begin
                w_rsp_valid_raw = m_r_valid_i[i];
                w_rsp_rdata     = m_r_rdata_i[i];
                w_rsp_opc       = m_r_opc_i[i];
            end
        end
        if (r_last_port == c_err_port) begin
            w_rsp_valid_raw = w_err_valid;
            w_rsp_rdata     = DATA_WIDTH'(FC_DEMUX_ERR_RDATA);
            w_rsp_opc       = 1'b1;
        end
        w_rsp_valid = w_rsp_valid_raw && (r_cnt != '0);
        s_r_valid_o = w_rsp_valid;
        s_r_rdata_o = w_rsp_valid ? w_rsp_rdata : '0;
        s_r_opc_o   = w_rsp_valid && w_rsp_opc;
    end

    // Outstanding counter and owning port; grant and response together cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_last_port <= '0;
        end else begin
            if (s_gnt_o && !w_rsp_valid) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!s_gnt_o && w_rsp_valid) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (s_gnt_o) begin
                r_last_port <= w_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_bus_demux.sv
// ============================================================================
// Module      : tb_fc_bus_demux
// Description : Directed self-checking bench for fc_bus_demux (2 ports,
//               L2 at 0x1C00_0000-0x1C08_0000, SCM at 0x1C10_0000-0x1C11_0000
//               with alias enabled, up to 4 outstanding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_bus_demux;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        s_req, s_wen, s_gnt, s_r_valid, s_r_opc;
    logic [31:0] s_add, s_wdata, s_r_rdata;
    logic [3:0]  s_be;
    logic [1:0]  m_req, m_wen, m_gnt, m_r_valid, m_r_opc;
    logic [31:0] m_add [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_r_rdata [2];
    logic [3:0]  m_be [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fc_bus_demux #(
        .N_PORTS         (2),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (4),
        .START_ADDR      ('{32'h1C00_0000, 32'h1C10_0000}),
        .END_ADDR        ('{32'h1C08_0000, 32'h1C11_0000}),
        .ALIAS_EN        (2'b10),
        .ALIAS_MASK      (32'h1C00_0000)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .s_req_i     (s_req),
        .s_add_i     (s_add),
        .s_wen_i     (s_wen),
        .s_wdata_i   (s_wdata),
        .s_be_i      (s_be),
        .s_gnt_o     (s_gnt),
        .s_r_valid_o (s_r_valid),
        .s_r_rdata_o (s_r_rdata),
        .s_r_opc_o   (s_r_opc),
        .m_req_o     (m_req),
        .m_add_o     (m_add),
        .m_wen_o     (m_wen),
        .m_wdata_o   (m_wdata),
        .m_be_o      (m_be),
        .m_gnt_i     (m_gnt),
        .m_r_valid_i (m_r_valid),
        .m_r_rdata_i (m_r_rdata),
        .m_r_opc_i   (m_r_opc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset, with stray responses present ----------------
        rst_ni = 1'b0; s_req = 1'b0; s_add = '0; s_wen = 1'b1; s_wdata = '0; s_be = 4'hF;
        m_gnt = 2'b00; m_r_valid = 2'b11; m_r_opc = 2'b11;
        m_r_rdata[0] = 32'h1111_1111; m_r_rdata[1] = 32'h2222_2222;
        tick(); tick();
        chk("rst_m_req",   m_req,     2'b00);
        chk("rst_gnt",     s_gnt,     1'b0);
        chk("rst_rvalid",  s_r_valid, 1'b0);
        chk("rst_rdata",   s_r_rdata, 32'h0);
        chk("rst_opc",     s_r_opc,   1'b0);
        chk("rst_cnt",     dut.r_cnt, 3'd0);
        m_r_valid = 2'b00; m_r_opc = 2'b00; m_r_rdata[0] = '0; m_r_rdata[1] = '0;
        tick(); rst_ni = 1'b1; tick();

        // ---------------- single read to L2, latency 2 ----------------
        s_req = 1'b1; s_add = 32'h1C00_0100; s_wen = 1'b1; m_gnt = 2'b01; #1;
        chk("t1_m_req",     m_req,    2'b01);
        chk("t1_gnt",       s_gnt,    1'b1);
        chk("t1_add_bcast", m_add[1], 32'h1C00_0100);
        tick(); s_req = 1'b0; m_gnt = 2'b00; #1;
        chk("t1_cnt1",      dut.r_cnt, 3'd1);
        chk("t1_no_rsp",    s_r_valid, 1'b0);
        tick(); m_r_valid = 2'b01; m_r_rdata[0] = 32'hCAFE_0001; #1;
        chk("t1_rvalid",    s_r_valid, 1'b1);
        chk("t1_rdata",     s_r_rdata, 32'hCAFE_0001);
        chk("t1_opc",       s_r_opc,   1'b0);
        tick(); m_r_valid = 2'b00; #1;
        chk("t1_cnt0",      dut.r_cnt, 3'd0);
        chk("t1_rvalid_off", s_r_valid, 1'b0);

        // ---------------- 4 back-to-back reads to SCM, then stall ----------------
        s_req = 1'b1; s_wen = 1'b1; m_gnt = 2'b10;
        for (int k = 0; k < 4; k++) begin
            s_add = 32'h1C10_0000 + 32'(k * 4); #1;
            chk("t2_gnt", s_gnt, 1'b1);
            tick();
        end
        s_add = 32'h1C10_0010; #1;
        chk("t2_cnt_full",   dut.r_cnt, 3'd4);
        chk("t2_stall_gnt",  s_gnt,     1'b0);
        chk("t2_stall_req",  m_req,     2'b00);
        tick();
        chk("t2_stall_gnt2", s_gnt,     1'b0);
        m_r_valid = 2'b10; m_r_rdata[1] = 32'hB000_0000; #1;
        chk("t2_rsp_valid",  s_r_valid, 1'b1);
        chk("t2_gnt_same_cycle", s_gnt, 1'b0);
        tick(); m_r_valid = 2'b00; #1;
        chk("t2_cnt3",       dut.r_cnt, 3'd3);
        chk("t2_gnt_next",   s_gnt,     1'b1);
        chk("t2_req_next",   m_req,     2'b10);
        tick(); s_req = 1'b0; m_gnt = 2'b00; #1;
        chk("t2_cnt4",       dut.r_cnt, 3'd4);
        for (int k = 1; k <= 4; k++) begin
            m_r_valid = 2'b10; m_r_rdata[1] = 32'hB000_0000 + 32'(k); #1;
            chk("t2_drain_rdata", s_r_rdata, 32'hB000_0000 + 32'(k));
            tick();
        end
        m_r_valid = 2'b00; #1;
        chk("t2_cnt0",       dut.r_cnt, 3'd0);

        // ---------------- port switch held until L2 write answers ----------------
        s_req = 1'b1; s_add = 32'h1C00_0200; s_wen = 1'b0; s_wdata = 32'h1234_5678;
        s_be = 4'b0011; m_gnt = 2'b01; #1;
        chk("t3_gnt0",   s_gnt,      1'b1);
        chk("t3_wdata",  m_wdata[1], 32'h1234_5678);
        chk("t3_be",     m_be[1],    4'b0011);
        chk("t3_wen",    m_wen,      2'b00);
        tick(); s_add = 32'h1C10_0100; s_wen = 1'b1; s_be = 4'hF; m_gnt = 2'b10; #1;
        chk("t3_held_req",  m_req, 2'b00);
        chk("t3_held_gnt",  s_gnt, 1'b0);
        tick();
        chk("t3_held_req2", m_req, 2'b00);
        m_r_valid = 2'b01; m_r_rdata[0] = 32'h0000_00AA; #1;
        chk("t3_rsp0_valid", s_r_valid, 1'b1);
        chk("t3_held_req3",  m_req,     2'b00);
        tick(); m_r_valid = 2'b00; #1;
        chk("t3_fwd_req",  m_req, 2'b10);
        chk("t3_fwd_gnt",  s_gnt, 1'b1);
        tick(); s_req = 1'b0; m_gnt = 2'b00; m_r_valid = 2'b10; m_r_rdata[1] = 32'h0000_00BB; #1;
        chk("t3_rsp1_rdata", s_r_rdata, 32'h0000_00BB);
        tick(); m_r_valid = 2'b00; #1;
        chk("t3_cnt0", dut.r_cnt, 3'd0);

        // ---------------- decode: alias and region bounds (no grants) ----------------
        s_req = 1'b1; m_gnt = 2'b00;
        s_add = 32'h0010_0040; #1; chk("t4_alias_p1",  m_req, 2'b10);
        s_add = 32'h1C07_FFFC; #1; chk("t4_p0_last",   m_req, 2'b01);
        s_add = 32'h1C10_FFFF; #1; chk("t4_p1_last",   m_req, 2'b10);
`ifdef FC_DEMUX_ERR_SLAVE_EN
        s_add = 32'h1C08_0000; #1; chk("t4_end_excl",  m_req, 2'b00);
        s_add = 32'h0000_0000; #1; chk("t4_no_alias0", m_req, 2'b00);
`else
        s_add = 32'h1C08_0000; #1; chk("t4_end_excl",  m_req, 2'b01);
        s_add = 32'h0000_0000; #1; chk("t4_no_alias0", m_req, 2'b01);
`endif
        s_req = 1'b0;
        tick();
        chk("t4_cnt_nogrant", dut.r_cnt, 3'd0);

        // ---------------- unmapped access ----------------
        s_req = 1'b1; s_add = 32'h0000_1000; s_wen = 1'b1; m_gnt = 2'b11; #1;
`ifdef FC_DEMUX_ERR_SLAVE_EN
        chk("t5_no_mreq", m_req, 2'b00);
        chk("t5_gnt",     s_gnt, 1'b1);
        tick(); s_req = 1'b0; m_gnt = 2'b00; #1;
        chk("t5_err_valid", s_r_valid, 1'b1);
        chk("t5_err_opc",   s_r_opc,   1'b1);
        chk("t5_err_rdata", s_r_rdata, 32'hBADA_CCE5);
        tick();
        chk("t5_valid_off", s_r_valid, 1'b0);
`else
        chk("t5_to_port0", m_req, 2'b01);
        chk("t5_gnt",      s_gnt, 1'b1);
        tick(); s_req = 1'b0; m_gnt = 2'b00; m_r_valid = 2'b01; m_r_rdata[0] = 32'h0000_5555; #1;
        chk("t5_p0_valid", s_r_valid, 1'b1);
        chk("t5_p0_rdata", s_r_rdata, 32'h0000_5555);
        chk("t5_p0_opc",   s_r_opc,   1'b0);
        tick(); m_r_valid = 2'b00; #1;
`endif
        chk("t5_cnt0", dut.r_cnt, 3'd0);

        // ---------------- reset with 3 outstanding, then stray response ----------------
        s_req = 1'b1; s_add = 32'h1C00_0000; m_gnt = 2'b01;
        repeat (3) tick();
        s_req = 1'b0; m_gnt = 2'b00; #1;
        chk("t6_cnt3", dut.r_cnt, 3'd3);
        rst_ni = 1'b0; #1;
        chk("t6_cnt_cleared", dut.r_cnt, 3'd0);
        chk("t6_rst_m_req",   m_req,     2'b00);
        chk("t6_rst_gnt",     s_gnt,     1'b0);
        chk("t6_rst_rvalid",  s_r_valid, 1'b0);
        tick(); rst_ni = 1'b1; tick();
        m_r_valid = 2'b01; m_r_rdata[0] = 32'hDEAD_BEEF; m_r_opc = 2'b01; #1;
        chk("t6_stray_valid", s_r_valid, 1'b0);
        chk("t6_stray_rdata", s_r_rdata, 32'h0);
        chk("t6_stray_opc",   s_r_opc,   1'b0);
        tick(); m_r_valid = 2'b00; m_r_opc = 2'b00; #1;
        chk("t6_cnt_stays0", dut.r_cnt, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
